// File: rtl/ann_feature_rx_pkg.sv
// Shared definitions for the ANN feature receive path.
// Holds channel/width defaults, the receive FSM state encoding and the
// C2 output map size that sets how many vectors make up one frame.
package ann_feature_rx_pkg;

  localparam int FEAT_DATA_W     = 8;
  localparam int FEAT_IN_CH      = 8;
  localparam int FEAT_FIFO_DEPTH = 4;

  // C2 feature map geometry; a valid convolution gives a 3x2 output map.
  localparam int C2_IMG_H = 5;
  localparam int C2_IMG_W = 4;
  localparam int K_DIM    = 3;
  localparam int C2_OUT_PIXELS = (C2_IMG_H - K_DIM + 1) * (C2_IMG_W - K_DIM + 1);

  typedef enum logic {
    RX_IDLE = 1'b0,
    RX_ACK  = 1'b1
  } rx_state_t;

endpackage

// File: rtl/ann_feature_rx_if.sv
// Bundle of the producer handshake and the serial output stream of ann_feature_rx.
// Producer side: i_req, i_data_flat in; o_ack out. Consumer side: o_valid,
// o_data, o_ch, o_last_ch, o_last_frame out; i_ready in. Status: o_proto_err, o_fifo_level.
interface ann_feature_rx_if
  import ann_feature_rx_pkg::*;
#(
  parameter int DATA_W     = FEAT_DATA_W,
  parameter int IN_CH      = FEAT_IN_CH,
  parameter int FIFO_DEPTH = FEAT_FIFO_DEPTH
) ();

  logic                          i_req;
  logic [IN_CH*DATA_W-1:0]       i_data_flat;
  logic                          o_ack;
  logic                          o_valid;
  logic                          i_ready;
  logic signed [DATA_W-1:0]      o_data;
  logic [$clog2(IN_CH)-1:0]      o_ch;
  logic                          o_last_ch;
  logic                          o_last_frame;
  logic                          o_proto_err;
  logic [$clog2(FIFO_DEPTH):0]   o_fifo_level;

  // The receiver block itself.
  modport slave (
    input  i_req, i_data_flat, i_ready,
    output o_ack, o_valid, o_data, o_ch, o_last_ch, o_last_frame,
           o_proto_err, o_fifo_level
  );

  // The producer/consumer environment around it.
  modport master (
    output i_req, i_data_flat, i_ready,
    input  o_ack, o_valid, o_data, o_ch, o_last_ch, o_last_frame,
           o_proto_err, o_fifo_level
  );

endinterface

// File: rtl/ann_feature_rx_vec_fifo.sv
// vec_fifo: single-clock FIFO of whole feature vectors with combinational head read.
// Ports: push/push_dat write the tail, pop retires the head, head shows the oldest
// entry, full/empty/level report occupancy. Caller must not push when full or pop when empty.
module vec_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_dat,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  // Storage needs no reset: occupancy alone decides what is readable.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_dat;
  end

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  assign head  = mem[rd_ptr];
  assign full  = (level == LW'(DEPTH));
  assign empty = (level == '0);

endmodule

// File: rtl/ann_feature_rx.sv
// ann_feature_rx: four-phase req/ack receiver for encoder feature vectors, buffered
// and re-emitted one channel per beat on a valid/ready stream with frame markers.
// Ports: clk, rst_n (async, active-low) and the ann_feature_rx_if slave bundle.
module ann_feature_rx
  import ann_feature_rx_pkg::*;
#(
  parameter int DATA_W     = FEAT_DATA_W,
  parameter int IN_CH      = FEAT_IN_CH,
  parameter int FIFO_DEPTH = FEAT_FIFO_DEPTH,
  parameter int FRAME_VECS = C2_OUT_PIXELS
) (
  input  logic             clk,
  input  logic             rst_n,
  ann_feature_rx_if.slave  bus
);

  localparam int VEC_W = IN_CH * DATA_W;
  localparam int CH_W  = $clog2(IN_CH);
  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
  localparam int VC_W  = (FRAME_VECS > 1) ? $clog2(FRAME_VECS) : 1;
  localparam logic [CH_W-1:0] LAST_CH  = CH_W'(IN_CH - 1);
  localparam logic [VC_W-1:0] LAST_VEC = VC_W'(FRAME_VECS - 1);

  rx_state_t        state;
  rx_state_t        state_nxt;
  logic             push;
  logic             pop;
  logic             full;
  logic             empty;
  logic             req_q;
  logic             proto_err;
  logic [VEC_W-1:0] head;
  logic [LVL_W-1:0] level;
  logic [CH_W-1:0]  ch_idx;
  logic [VC_W-1:0]  vec_cnt;
  logic             valid;
  logic             accept;
  logic             at_last_ch;

  vec_fifo #(
    .WIDTH (VEC_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push),
    .push_dat (bus.i_data_flat),
    .pop      (pop),
    .head     (head),
    .full     (full),
    .empty    (empty),
    .level    (level)
  );

  // ---------------- receive handshake ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= RX_IDLE;
    else        state <= state_nxt;
  end

  // full is the pre-pop occupancy, so a pop on this edge cannot admit a push.
  always_comb begin
    state_nxt = state;
    push      = 1'b0;
    case (state)
      RX_IDLE: begin
        if (bus.i_req && !full) begin
          push      = 1'b1;
          state_nxt = RX_ACK;
        end
      end
      RX_ACK: begin
        if (!bus.i_req) state_nxt = RX_IDLE;
      end
      default: state_nxt = RX_IDLE;
    endcase
  end

  // A falling request while ack is still low means the producer withdrew a
  // request that was never acknowledged; latch it until reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q     <= 1'b0;
      proto_err <= 1'b0;
    end else begin
      req_q <= bus.i_req;
      if (state == RX_IDLE && req_q && !bus.i_req) proto_err <= 1'b1;
    end
  end

  // ---------------- channel serializer ----------------
  assign valid      = !empty;
  assign at_last_ch = (ch_idx == LAST_CH);
  assign accept     = valid && bus.i_ready;
  assign pop        = accept && at_last_ch;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ch_idx  <= '0;
      vec_cnt <= '0;
    end else if (accept) begin
      if (at_last_ch) begin
        ch_idx  <= '0;
        vec_cnt <= (vec_cnt == LAST_VEC) ? '0 : vec_cnt + VC_W'(1);
      end else begin
        ch_idx <= ch_idx + CH_W'(1);
      end
    end
  end

  assign bus.o_ack        = (state == RX_ACK);
  assign bus.o_valid      = valid;
  // Gated so stale storage never shows on the bus while empty.
  assign bus.o_data       = valid ? head[int'(ch_idx)*DATA_W +: DATA_W] : '0;
  assign bus.o_ch         = ch_idx;
  assign bus.o_last_ch    = valid && at_last_ch;
  assign bus.o_last_frame = valid && at_last_ch && (vec_cnt == LAST_VEC);
  assign bus.o_proto_err  = proto_err;
  assign bus.o_fifo_level = level;

endmodule

// File: tb/tb_ann_feature_rx.sv
// Self-checking bench for ann_feature_rx: queue-based reference model compared every cycle,
// plus literal checks of handshake timing, backpressure, frames, sign passthrough and reset.
module tb_ann_feature_rx;

  localparam int DW    = 8;
  localparam int NCH   = 8;
  localparam int DEPTH = 4;
  localparam int FV    = 6;

  logic clk;
  logic rst_n;

  ann_feature_rx_if #(.DATA_W(DW), .IN_CH(NCH), .FIFO_DEPTH(DEPTH)) bus ();

  ann_feature_rx #(
    .DATA_W     (DW),
    .IN_CH      (NCH),
    .FIFO_DEPTH (DEPTH),
    .FRAME_VECS (FV)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  function automatic void chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s t=%0t got=%0h expected=%0h", name, $time, got, exp);
    end
  endfunction

  // ---------------- reference model ----------------
  logic [63:0] mq[$];
  int          m_ch    = 0;
  int          m_vec   = 0;
  bit          m_ack   = 0;
  bit          m_err   = 0;
  bit          m_req_q = 0;

  initial forever begin
    int pre_level;
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      mq.delete();
      m_ch = 0; m_vec = 0; m_ack = 0; m_err = 0; m_req_q = 0;
    end else begin
      pre_level = mq.size();
      if (mq.size() > 0 && bus.i_ready) begin
        if (m_ch == NCH - 1) begin
          void'(mq.pop_front());
          m_ch  = 0;
          m_vec = (m_vec + 1) % FV;
        end else begin
          m_ch++;
        end
      end
      if (!m_ack) begin
        if (m_req_q && !bus.i_req) m_err = 1;
        if (bus.i_req && pre_level < DEPTH) begin
          mq.push_back(bus.i_data_flat);
          m_ack = 1;
        end
      end else if (!bus.i_req) begin
        m_ack = 0;
      end
      m_req_q = bus.i_req;
    end
  end

  // ---------------- per-cycle compare + output log ----------------
  logic [7:0] log_dat[$];
  int         log_ch[$];
  bit         log_lc[$];
  bit         log_lf[$];

  initial forever begin
    bit          ev;
    logic [63:0] hv;
    logic [7:0]  ed;
    @(negedge clk);
    ev = (mq.size() > 0);
    hv = ev ? mq[0] : 64'd0;
    ed = hv[m_ch*DW +: DW];
    chk("valid", bus.o_valid, ev);
    chk("data", $unsigned(bus.o_data), ed);
    chk("ch", bus.o_ch, m_ch);
    chk("last_ch", bus.o_last_ch, ev && m_ch == NCH - 1);
    chk("last_frame", bus.o_last_frame, ev && m_ch == NCH - 1 && m_vec == FV - 1);
    chk("ack", bus.o_ack, m_ack);
    chk("proto_err", bus.o_proto_err, m_err);
    chk("level", bus.o_fifo_level, mq.size());
    if (rst_n && bus.o_valid && bus.i_ready) begin
      log_dat.push_back(bus.o_data);
      log_ch.push_back(int'(bus.o_ch));
      log_lc.push_back(bus.o_last_ch);
      log_lf.push_back(bus.o_last_frame);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [63:0] v, input int hold);
    int n;
    bus.i_req       = 1'b1;
    bus.i_data_flat = v;
    n = 0;
    do begin cyc(); n++; end while (!bus.o_ack && n < 400);
    chk("send_ack_rise", bus.o_ack, 1);
    repeat (hold) cyc();
    bus.i_req       = 1'b0;
    bus.i_data_flat = {$urandom, $urandom};
    n = 0;
    do begin cyc(); n++; end while (bus.o_ack && n < 400);
    chk("send_ack_fall", bus.o_ack, 0);
  endtask

  task automatic drain();
    int n;
    bus.i_ready = 1'b1;
    n = 0;
    while ((bus.o_valid || bus.o_fifo_level != 0) && n < 400) begin cyc(); n++; end
    chk("drain_level", bus.o_fifo_level, 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) cyc();
    rst_n = 1'b1;
    cyc();
  endtask

  logic [63:0] sent[$];
  bit          rnd_done;

  initial begin
    #500000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int b;
    int n;
    int lf;
    logic [63:0] v;

    rst_n           = 1'b0;
    bus.i_req       = 1'b0;
    bus.i_data_flat = '0;
    bus.i_ready     = 1'b0;
    repeat (3) cyc();
    chk("rst_valid", bus.o_valid, 0);
    chk("rst_ack", bus.o_ack, 0);
    chk("rst_level", bus.o_fifo_level, 0);
    chk("rst_data", $unsigned(bus.o_data), 0);
    rst_n = 1'b1;
    cyc();

    // Single vector with explicit handshake timing.
    bus.i_ready = 1'b1;
    b = log_dat.size();
    bus.i_req       = 1'b1;
    bus.i_data_flat = 64'h0706050403020100;
    chk("sv_ack_before", bus.o_ack, 0);
    cyc();
    chk("sv_ack_rise", bus.o_ack, 1);
    chk("sv_valid_rise", bus.o_valid, 1);
    bus.i_req = 1'b0;
    cyc();
    chk("sv_ack_fall", bus.o_ack, 0);
    drain();
    chk("sv_count", log_dat.size() - b, 8);
    for (int i = 0; i < 8; i++) begin
      chk("sv_data", log_dat[b+i], i);
      chk("sv_ch", log_ch[b+i], i);
      chk("sv_last_ch", log_lc[b+i], i == 7);
    end

    // Backpressure: four fill the FIFO, the fifth waits for a pop.
    bus.i_ready = 1'b0;
    for (int k = 0; k < 4; k++) send({$urandom, $urandom}, 0);
    chk("bp_level_full", bus.o_fifo_level, 4);
    bus.i_req       = 1'b1;
    bus.i_data_flat = {$urandom, $urandom};
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk("bp_fifth_held", bus.o_ack, 0);
    end
    bus.i_ready = 1'b1;
    n = 0;
    do begin cyc(); n++; end while (!bus.o_ack && n < 50);
    chk("bp_ack_after_pop", n, 9);
    bus.i_req = 1'b0;
    cyc();
    drain();

    // Frame boundaries over 12 vectors from a clean start.
    do_reset();
    bus.i_ready = 1'b1;
    b = log_dat.size();
    for (int k = 0; k < 12; k++) send({$urandom, $urandom}, 0);
    drain();
    lf = 0;
    for (int i = b; i < log_lf.size(); i++) lf += int'(log_lf[i]);
    chk("frame_pulses", lf, 2);
    chk("frame_at_v6", log_lf[b+47], 1);
    chk("frame_at_v12", log_lf[b+95], 1);

    // Signed values pass through unchanged.
    b = log_dat.size();
    v = {$urandom, $urandom};
    v[7:0]  = 8'h80;
    v[15:8] = 8'hFF;
    send(v, 1);
    drain();
    chk("signed_m128", log_dat[b], 8'h80);
    chk("signed_m1", log_dat[b+1], 8'hFF);

    // Output stall: ready toggles every cycle during three transfers.
    b = log_dat.size();
    sent.delete();
    for (int k = 0; k < 3; k++) sent.push_back({$urandom, $urandom});
    fork
      begin
        repeat (60) begin bus.i_ready = ~bus.i_ready; cyc(); end
      end
      begin
        for (int k = 0; k < 3; k++) send(sent[k], 0);
      end
    join
    drain();
    chk("stall_count", log_dat.size() - b, 24);
    for (int i = 0; i < 24; i++) begin
      v = sent[i/8];
      chk("stall_data", log_dat[b+i], v[(i%8)*8 +: 8]);
    end

    // Randomized compliant traffic with random downstream ready.
    rnd_done = 0;
    fork
      begin
        while (!rnd_done) begin bus.i_ready = 1'($urandom); cyc(); end
      end
      begin
        for (int k = 0; k < 30; k++) begin
          send({$urandom, $urandom}, $urandom_range(0, 3));
          repeat ($urandom_range(0, 2)) cyc();
        end
        rnd_done = 1;
      end
    join
    drain();

    // Protocol error: request withdrawn while blocked by a full FIFO.
    bus.i_ready = 1'b0;
    for (int k = 0; k < 4; k++) send({$urandom, $urandom}, 0);
    bus.i_req = 1'b1;
    repeat (2) cyc();
    bus.i_req = 1'b0;
    cyc();
    chk("proto_set", bus.o_proto_err, 1);
    repeat (5) cyc();
    chk("proto_sticky", bus.o_proto_err, 1);

    // Reset in the middle of a drain.
    bus.i_ready = 1'b1;
    repeat (10) cyc();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", bus.o_valid, 0);
    chk("mid_rst_level", bus.o_fifo_level, 0);
    chk("mid_rst_err", bus.o_proto_err, 0);
    chk("mid_rst_data", $unsigned(bus.o_data), 0);
    chk("mid_rst_ch", bus.o_ch, 0);
    chk("mid_rst_last", {bus.o_last_ch, bus.o_last_frame, bus.o_ack}, 0);
    cyc();
    rst_n = 1'b1;
    repeat (3) cyc();
    chk("post_rst_level", bus.o_fifo_level, 0);
    chk("post_rst_err", bus.o_proto_err, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
